mul_div_unit: RTL

//  Iterative 32-cycle multiply/divide unit for the EX stage of each core.
//  hi_o/lo_o feed data1_i of the write-back MUX_2to1 (ALU result on data0_i);

---
 rtl/mul_div_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit for the EX stage.
// One operation in flight at a time. A radix-2 shift-add multiply or a
// restoring divide runs on operand magnitudes for WIDTH cycles. The sign is
// applied on entry to DONE.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous reset, active-high
//   start_i     request a new op; accepted only while idle
//   op_i        00 MULU, 01 MUL, 10 DIVU, 11 DIV
//   src_a_i     multiplicand / dividend
//   src_b_i     multiplier / divisor
//   busy_o      unit not idle
//   done_o      one-cycle pulse, hi_o/lo_o valid
//   div_zero_o  divide by zero, valid with done_o
//   hi_o        product high half / remainder
//   lo_o        product low half / quotient
//
// state  | meaning
// S_IDLE | waiting for start_i
// S_RUN  | iterating; counter reaching zero moves to S_DONE
// S_DONE | result registered, done_o pulse
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               dz_q, dz_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shl;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    dvs_d    = dvs_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;

    a_neg = op_i[0] & src_a_i[WIDTH-1];
    b_neg = op_i[0] & src_b_i[WIDTH-1];
    a_mag = a_neg ? -src_a_i : src_a_i;
    b_mag = b_neg ? -src_b_i : src_b_i;

    // Multiply step: accumulator high half gains the multiplicand when the
    // current multiplier bit (acc_q[0]) is set, then everything shifts right.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);

    // Restoring divide step. The partial remainder is always below the
    // divisor, so shl - divisor fits in WIDTH+1 signed bits and its top bit
    // is the "does not fit" flag.
    div_shl  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_shl - {1'b0, dvs_q};
    div_ge   = ~div_diff[WIDTH];

    prod_fix = neg_lo_q ? -acc_q : acc_q;
    quo_fix  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_RUN;
          is_div_d = op_i[1];
          dvs_d    = b_mag;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          dz_d     = op_i[1] && (src_b_i == '0);
          if (op_i[1] && (src_b_i == '0)) begin
            // Skip the iterations; result is preloaded raw.
            acc_d = {src_a_i, {WIDTH{1'b1}}};
            cnt_d = '0;
          end else begin
            acc_d = {{WIDTH{1'b0}}, a_mag};
            cnt_d = CW'(WIDTH);
          end
        end
      end
      S_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          if (is_div_q) begin
            if (div_ge)
              acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
              acc_d = {div_shl[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
        end else begin
          state_d = S_DONE;
          if (dz_q) begin
            hi_d = acc_q[2*WIDTH-1:WIDTH];
            lo_d = acc_q[WIDTH-1:0];
          end else if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      dvs_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      dvs_q    <= dvs_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign div_zero_o = (state_q == S_DONE) && dz_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule
